l2_cache_control: RTL and testbench

Sequencing controller for the two-way, write-back L2 cache datapath. It sits between the L1 side (whole-line read/write requests held until `mem_resp`) and physical memory. It drives the datapath's write, allocate, mux-select and valid/dirty inputs from the datapath's `cache_hit` and `dirtyout` status, and runs the writeback and line-fill handshakes with physical memory. It also keeps saturating hit, miss and writeback counters for performance measurement.

---
 rtl/l2_cache_control.sv | 120 ++++++++++++
 tb/tb_l2_cache_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// Two-way write-back L2 sequencer: hits complete in 2 cycles, misses add writeback (W) and fill (F) time.
// The L1 request is held until mem_resp. The FSM waits on pmem_resp, and pmem transactions always run to completion.
module l2_cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   input  logic                 cache_hit,
   input  logic                 dirtyout,
   input  logic                 pmem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 write_enable,
   output logic                 cache_allocate,
   output logic                 datain_mux_sel,
   output logic                 valid_in,
   output logic                 dirty_datain,
   output logic                 pmem_address_sel,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FETCH} state_t;

   state_t state;
   logic   refill;
   logic   req;

   assign req = mem_read | mem_write;

   always_comb begin
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      write_enable     = 1'b0;
      cache_allocate   = 1'b0;
      datain_mux_sel   = 1'b0;
      valid_in         = 1'b0;
      dirty_datain     = 1'b0;
      pmem_address_sel = 1'b0;
      case (state)
         CHECK: begin
            if (req && cache_hit) begin
               mem_resp = 1'b1;
               if (mem_write) begin
                  write_enable   = 1'b1;
                  datain_mux_sel = 1'b1;
                  valid_in       = 1'b1;
                  dirty_datain   = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            pmem_write       = 1'b1;
            pmem_address_sel = 1'b1;
         end
         FETCH: begin
            pmem_read = 1'b1;
            // The fill is written into the LRU way in the same cycle that the memory responds.
            if (pmem_resp) begin
               write_enable   = 1'b1;
               cache_allocate = 1'b1;
               valid_in       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         refill     <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state  <= CHECK;
                  refill <= 1'b0;
               end
            end
            CHECK: begin
               if (!req) begin
                  state <= IDLE;
               end else if (cache_hit) begin
                  state <= IDLE;
                  if (!refill && hit_count != '1)
                     hit_count <= hit_count + 1'b1;
               end else begin
                  // A miss on the post-fill re-check is retried but is not counted a second time.
                  if (!refill && miss_count != '1)
                     miss_count <= miss_count + 1'b1;
                  state <= dirtyout ? WRITEBACK : FETCH;
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  state <= FETCH;
                  if (wb_count != '1)
                     wb_count <= wb_count + 1'b1;
               end
            end
            FETCH: begin
               if (pmem_resp) begin
                  state  <= CHECK;
                  refill <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: table vectors, hand-written corner sequences and random transactions checked against a transaction-level model.
module tb_l2_cache_control;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_read = 1'b0, mem_write = 1'b0, cache_hit = 1'b0, dirtyout = 1'b0, pmem_resp = 1'b0;
   logic          mem_resp, pmem_read, pmem_write, write_enable, cache_allocate;
   logic          datain_mux_sel, valid_in, dirty_datain, pmem_address_sel;
   logic [CW-1:0] hit_count, miss_count, wb_count;
   logic [8:0]    outs;

   int checks = 0;
   int errors = 0;
   int m_hit, m_miss, m_wb;

   // Values observed during a transaction, filled in by run_txn.
   int         o_lat, o_rd, o_wr, o_we, o_fill, o_bad, o_resp, o_done, o_idle;
   logic [4:0] o_resp_outs;

   typedef struct {
      bit wr;
      bit hit;
      bit dirty;
      int wl;
      int fl;
      int lat;
      int rd;
      int wrc;
      int we;
   } vec_t;

   vec_t vecs[6];

   l2_cache_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .cache_hit(cache_hit), .dirtyout(dirtyout), .pmem_resp(pmem_resp), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .write_enable(write_enable), .cache_allocate(cache_allocate),
      .datain_mux_sel(datain_mux_sel), .valid_in(valid_in), .dirty_datain(dirty_datain),
      .pmem_address_sel(pmem_address_sel), .hit_count(hit_count), .miss_count(miss_count),
      .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   assign outs = {mem_resp, pmem_read, pmem_write, write_enable, cache_allocate,
                  datain_mux_sel, valid_in, dirty_datain, pmem_address_sel};

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      #2;
      reset     = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
      cache_hit = 1'b0;
      dirtyout  = 1'b0;
      #1;
      chk("reset_outs", outs, 0);
      chk("reset_counters", {hit_count, miss_count, wb_count}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_hit = 0; m_miss = 0; m_wb = 0;
   endtask

   // Plays the datapath and memory: cache_hit goes high after the fill, and pmem_resp is raised in the last cycle of each transfer.
   task automatic run_txn(input bit wr, input bit hit0, input bit dirty, input int wl, input int fl);
      int edges;
      bit filled;
      @(posedge clk); #1;
      mem_read  = !wr;
      mem_write = wr;
      cache_hit = hit0;
      dirtyout  = dirty;
      pmem_resp = 1'b0;
      edges = 0; filled = 0;
      o_lat = 0; o_rd = 0; o_wr = 0; o_we = 0; o_fill = 0; o_bad = 0; o_resp = 0; o_done = 0;
      o_resp_outs = '0;
      while (!o_done && edges < 200) begin
         @(posedge clk); #1;
         edges++;
         pmem_resp = 1'b0;
         if (filled) cache_hit = 1'b1;
         if (pmem_write) begin
            o_wr++;
            pmem_resp = (o_wr == wl);
         end else if (pmem_read) begin
            o_rd++;
            pmem_resp = (o_rd == fl);
         end
         #1;
         if (pmem_read && pmem_write) o_bad++;
         if (write_enable && (pmem_write || (pmem_read && !pmem_resp))) o_bad++;
         if (pmem_write && !pmem_address_sel) o_bad++;
         if (pmem_read && pmem_address_sel) o_bad++;
         if (write_enable) o_we++;
         if (pmem_read && pmem_resp) begin
            filled = 1;
            if (write_enable && cache_allocate && valid_in && !dirty_datain && !datain_mux_sel) o_fill++;
            else o_bad++;
         end
         if (mem_resp) begin
            o_resp++;
            o_lat  = edges + 1;
            o_done = 1;
            o_resp_outs = {write_enable, datain_mux_sel, dirty_datain, valid_in, cache_allocate};
         end
      end
      // The request is still held here, but the FSM must sit in IDLE for one cycle.
      @(posedge clk); #1;
      o_idle = outs;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      pmem_resp = 1'b0;
   endtask

   task automatic model_txn(input bit hit0, input bit dirty);
      if (hit0) begin
         if (m_hit < SAT) m_hit++;
      end else begin
         if (m_miss < SAT) m_miss++;
         if (dirty && m_wb < SAT) m_wb++;
      end
   endtask

   task automatic check_txn(input string tag, input bit wr, input int lat, input int rd, input int wrc,
                            input int we, input int fill);
      chk({tag, "_done"}, o_done, 1);
      chk({tag, "_lat"}, o_lat, lat);
      chk({tag, "_resp_pulses"}, o_resp, 1);
      chk({tag, "_pmem_read_cycles"}, o_rd, rd);
      chk({tag, "_pmem_write_cycles"}, o_wr, wrc);
      chk({tag, "_we_cycles"}, o_we, we);
      chk({tag, "_fill"}, o_fill, fill);
      chk({tag, "_resp_outs"}, o_resp_outs, wr ? 5'b11110 : 5'b00000);
      chk({tag, "_invariants"}, o_bad, 0);
      chk({tag, "_idle_after_resp"}, o_idle, 0);
      chk({tag, "_hit_count"}, hit_count, m_hit);
      chk({tag, "_miss_count"}, miss_count, m_miss);
      chk({tag, "_wb_count"}, wb_count, m_wb);
   endtask

   initial begin
      vecs[0] = '{wr:0, hit:1, dirty:0, wl:0, fl:0, lat:2, rd:0, wrc:0, we:0};
      vecs[1] = '{wr:1, hit:1, dirty:1, wl:0, fl:0, lat:2, rd:0, wrc:0, we:1};
      vecs[2] = '{wr:0, hit:0, dirty:0, wl:0, fl:5, lat:8, rd:5, wrc:0, we:1};
      vecs[3] = '{wr:1, hit:0, dirty:1, wl:3, fl:2, lat:8, rd:2, wrc:3, we:2};
      vecs[4] = '{wr:0, hit:0, dirty:1, wl:1, fl:1, lat:5, rd:1, wrc:1, we:1};
      vecs[5] = '{wr:1, hit:0, dirty:0, wl:0, fl:1, lat:4, rd:1, wrc:0, we:2};

      do_reset();
      foreach (vecs[i]) begin
         run_txn(vecs[i].wr, vecs[i].hit, vecs[i].dirty, vecs[i].wl, vecs[i].fl);
         model_txn(vecs[i].hit, vecs[i].dirty);
         check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].lat, vecs[i].rd, vecs[i].wrc,
                   vecs[i].we, vecs[i].hit ? 0 : 1);
      end
      chk("table_total_hits", hit_count, 2);
      chk("table_total_misses", miss_count, 4);
      chk("table_total_wbs", wb_count, 2);

      // Asynchronous reset in the middle of a fill.
      do_reset();
      @(posedge clk); #1;
      mem_read = 1'b1; cache_hit = 1'b0; dirtyout = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_pmem_read", pmem_read, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_pmem_read", pmem_read, 0);
      chk("async_reset_outs", outs, 0);
      chk("async_reset_miss_count", miss_count, 0);
      mem_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_idle", outs, 0);
      m_hit = 0; m_miss = 0; m_wb = 0;

      // A request dropped during CHECK goes back to IDLE without any side effects.
      @(posedge clk); #1;
      mem_read = 1'b1; cache_hit = 1'b0; dirtyout = 1'b1;
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      chk("drop_no_pmem", outs, 0);
      @(posedge clk); #1;
      chk("drop_still_idle", outs, 0);
      chk("drop_miss_count", miss_count, 0);

      // A miss on the post-fill re-check triggers another fill but does not add to miss_count.
      do_reset();
      @(posedge clk); #1;
      mem_read = 1'b1; cache_hit = 1'b0; dirtyout = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("refill_first_fetch", pmem_read, 1);
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      @(posedge clk); #1;
      chk("refill_second_fetch", pmem_read, 1);
      cache_hit = 1'b1;
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      #1;
      chk("refill_resp", mem_resp, 1);
      @(posedge clk); #1;
      mem_read = 1'b0;
      chk("refill_miss_count", miss_count, 1);
      chk("refill_hit_count", hit_count, 0);

      // Saturating counter test.
      do_reset();
      for (int n = 1; n <= 17; n++) begin
         run_txn(1'b0, 1'b1, 1'b0, 0, 0);
         if (n == 15) chk("sat_hit_at_15", hit_count, SAT);
      end
      chk("sat_hit_at_17", hit_count, SAT);
      chk("sat_miss_zero", miss_count, 0);

      // Random transactions against the model.
      do_reset();
      for (int t = 0; t < 40; t++) begin
         bit r_wr, r_hit, r_dirty;
         int r_wl, r_fl, e_lat;
         r_wr    = 1'($urandom_range(0, 1));
         r_hit   = 1'($urandom_range(0, 1));
         r_dirty = 1'($urandom_range(0, 1));
         r_wl    = int'($urandom_range(1, 6));
         r_fl    = int'($urandom_range(1, 6));
         run_txn(r_wr, r_hit, r_dirty, r_wl, r_fl);
         model_txn(r_hit, r_dirty);
         if (r_hit) e_lat = 2;
         else if (r_dirty) e_lat = r_wl + r_fl + 3;
         else e_lat = r_fl + 3;
         check_txn($sformatf("rnd%0d", t), r_wr, e_lat,
                   r_hit ? 0 : r_fl,
                   (!r_hit && r_dirty) ? r_wl : 0,
                   r_hit ? int'(r_wr) : 1 + int'(r_wr),
                   r_hit ? 0 : 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
